// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Walks the push and pop masks of a decoded stack instruction, issuing one
// 16-bit stack bus cycle per selected register. Pushes run first in ascending
// bit order (lowest set bit each time), pops follow in descending bit order
// (highest set bit each time). SP is tracked locally and written back once in
// the FINISH cycle.
//
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   start               begin a sequence (only honoured while idle)
//   push_mask/pop_mask  STACK_* register masks, latched on accepted start
//   sp_in               SP at start, latched
//   operand_in          word pushed for STACK_OPERAND
//   reg_rdata           register-file read data for reg_sel
//   busy                high while a sequence is in flight (incl. done cycle)
//   mem_req/mem_wr      stack bus request, 1 = write
//   mem_addr/mem_wdata  SS-relative offset and push data
//   mem_ack/mem_rdata   transfer completion and pop data
//   reg_sel             one-hot register of the current transfer / writeback
//   reg_we/reg_wdata    register-file write strobe and data (pops)
//   operand_out/valid   popped STACK_OPERAND word and its update pulse
//   sp_we/sp_out        final SP write-back
//   done                one-cycle completion pulse
// ---------------------------------------------------------------------------
module stack_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] push_mask,
    input  logic [15:0] pop_mask,
    input  logic [15:0] sp_in,
    input  logic [15:0] operand_in,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] reg_sel,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic [15:0] operand_out,
    output logic        operand_valid,
    output logic        sp_we,
    output logic [15:0] sp_out,
    output logic        done
);

    localparam logic [15:0] STACK_SP         = 16'h0010;
    localparam logic [15:0] STACK_SP_DISCARD = 16'h0020;
    localparam logic [15:0] STACK_OPERAND    = 16'h8000;

    typedef enum logic [1:0] {IDLE, PUSH, POP, FINISH} state_t;

    state_t      state, next_state;
    logic [15:0] push_rem, pop_rem;
    logic [15:0] sp_cur, sp_orig;
    logic [15:0] push_bit, pop_bit;
    logic        push_skip;
    logic        wb_we, wb_op;
    logic [15:0] wb_sel, wb_data, operand_q;

    // Lowest set bit of the remaining push mask (two's-complement trick) and
    // highest set bit of the remaining pop mask (last match in the scan wins).
    always_comb begin
        push_bit = push_rem & (~push_rem + 16'd1);
        pop_bit  = '0;
        for (int i = 0; i < 16; i++) begin
            if (pop_rem[i]) pop_bit = 16'd1 << i;
        end
        push_skip = (push_bit == STACK_SP_DISCARD);
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic. A bit retires on ack, or on its own for a pushed
    // SP_DISCARD, and the phase ends once the remaining mask would be empty.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (push_mask != 16'd0)     next_state = PUSH;
                    else if (pop_mask != 16'd0) next_state = POP;
                    else                        next_state = FINISH;
                end
            end
            PUSH: begin
                if ((push_skip || mem_ack) && ((push_rem & ~push_bit) == 16'd0))
                    next_state = (pop_rem != 16'd0) ? POP : FINISH;
            end
            POP: begin
                if (mem_ack && ((pop_rem & ~pop_bit) == 16'd0))
                    next_state = FINISH;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latched masks, SP tracking and the registered pop writeback.
    // Writeback strobes default low so they only last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_rem  <= '0;
            pop_rem   <= '0;
            sp_cur    <= '0;
            sp_orig   <= '0;
            wb_we     <= 1'b0;
            wb_op     <= 1'b0;
            wb_sel    <= '0;
            wb_data   <= '0;
            operand_q <= '0;
        end else begin
            wb_we <= 1'b0;
            wb_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        push_rem <= push_mask;
                        pop_rem  <= pop_mask;
                        sp_cur   <= sp_in;
                        sp_orig  <= sp_in;
                    end
                end
                PUSH: begin
                    if (push_skip) begin
                        push_rem <= push_rem & ~push_bit;
                    end else if (mem_ack) begin
                        push_rem <= push_rem & ~push_bit;
                        sp_cur   <= sp_cur - 16'd2;
                    end
                end
                POP: begin
                    if (mem_ack) begin
                        pop_rem <= pop_rem & ~pop_bit;
                        sp_cur  <= sp_cur + 16'd2;
                        wb_sel  <= pop_bit;
                        wb_data <= mem_rdata;
                        if (pop_bit == STACK_OPERAND) begin
                            wb_op     <= 1'b1;
                            operand_q <= mem_rdata;
                        end else if (pop_bit != STACK_SP && pop_bit != STACK_SP_DISCARD) begin
                            wb_we <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. A pending register writeback owns reg_sel for its cycle, even
    // when it overlaps the next pop request.
    always_comb begin
        busy          = (state != IDLE);
        mem_req       = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        reg_sel       = '0;
        sp_we         = 1'b0;
        sp_out        = '0;
        done          = 1'b0;
        case (state)
            PUSH: begin
                if (!push_skip) begin
                    mem_req  = 1'b1;
                    mem_wr   = 1'b1;
                    mem_addr = sp_cur - 16'd2;
                    reg_sel  = push_bit;
                    if (push_bit == STACK_SP)           mem_wdata = sp_orig;
                    else if (push_bit == STACK_OPERAND) mem_wdata = operand_in;
                    else                                mem_wdata = reg_rdata;
                end
            end
            POP: begin
                mem_req  = 1'b1;
                mem_addr = sp_cur;
                reg_sel  = pop_bit;
            end
            FINISH: begin
                sp_we  = 1'b1;
                sp_out = sp_cur;
                done   = 1'b1;
            end
            default: ;
        endcase
        if (wb_we) reg_sel = wb_sel;
        reg_we        = wb_we;
        reg_wdata     = wb_we ? wb_data : 16'd0;
        operand_valid = wb_op;
        operand_out   = operand_q;
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_sequencer
//
// Directed bench for stack_sequencer. A small register-file model returns
// 0xA000 + bit index for the selected register; the stack bus is driven
// step by step with hand-chosen ack timing and read data.
// ---------------------------------------------------------------------------
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, mem_ack;
    logic [15:0] push_mask, pop_mask, sp_in, operand_in, reg_rdata, mem_rdata;
    logic        busy, mem_req, mem_wr, reg_we, operand_valid, sp_we, done;
    logic [15:0] mem_addr, mem_wdata, reg_sel, reg_wdata, operand_out, sp_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int reg_we_count = 0;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in),
        .operand_in(operand_in), .reg_rdata(reg_rdata), .busy(busy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_sel(reg_sel), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .operand_out(operand_out), .operand_valid(operand_valid),
        .sp_we(sp_we), .sp_out(sp_out), .done(done)
    );

    // Register-file model: each register reads back 0xA000 + its bit index.
    always_comb begin
        reg_rdata = 16'hA0FF;
        for (int i = 0; i < 16; i++) begin
            if (reg_sel[i]) reg_rdata = 16'hA000 + 16'(i);
        end
    end

    // Counts register write strobes away from the active edge.
    always @(negedge clk) begin
        if (reg_we) reg_we_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] pm, input logic [15:0] pp, input logic [15:0] sp);
        push_mask = pm;
        pop_mask  = pp;
        sp_in     = sp;
        start     = 1'b1;
        t0        = cyc;
        step();
        start     = 1'b0;
    endtask

    // One bus transfer with 'waits' unacknowledged cycles; request signals
    // are re-checked every cycle to confirm they hold stable. sel == 0 skips
    // the reg_sel check.
    task automatic xfer(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] sel,
                        input logic [15:0] rdata, input int waits);
        for (int w = 0; w <= waits; w++) begin
            checkOutput({tag, " mem_req"}, {15'd0, mem_req}, 16'd1);
            checkOutput({tag, " mem_wr"}, {15'd0, mem_wr}, {15'd0, wr});
            checkOutput({tag, " mem_addr"}, mem_addr, addr);
            if (wr) checkOutput({tag, " mem_wdata"}, mem_wdata, wdata);
            if (sel != 16'd0) checkOutput({tag, " reg_sel"}, reg_sel, sel);
            if (w == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            step();
            mem_ack   = 1'b0;
            mem_rdata = 16'd0;
        end
    endtask

    task automatic check_finish(input string tag, input logic [15:0] sp, input int dt);
        checkOutput({tag, " done"}, {15'd0, done}, 16'd1);
        checkOutput({tag, " sp_we"}, {15'd0, sp_we}, 16'd1);
        checkOutput({tag, " sp_out"}, sp_out, sp);
        checkOutput({tag, " done_time"}, 16'(cyc - t0), 16'(dt));
        checkOutput({tag, " no_req_at_done"}, {15'd0, mem_req}, 16'd0);
        step();
        checkOutput({tag, " busy_after"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, " done_after"}, {15'd0, done}, 16'd0);
    endtask

    // PUSH R with mask 0x01DF from SP 0x1000. abort_after >= 0 asserts reset
    // in that transfer's request cycle; otherwise a stray start is pulsed
    // mid-sequence and must be ignored.
    task automatic push_r(input int abort_after);
        int bits [8] = '{0, 1, 2, 3, 4, 6, 7, 8};
        logic [15:0] wd;
        applyStimulus(16'h01DF, 16'h0000, 16'h1000);
        for (int k = 0; k < 8; k++) begin
            if (k == abort_after) begin
                reset = 1'b1;
                #1;
                checkOutput("abort mem_req", {15'd0, mem_req}, 16'd0);
                checkOutput("abort busy", {15'd0, busy}, 16'd0);
                checkOutput("abort reg_sel", reg_sel, 16'd0);
                checkOutput("abort mem_addr", mem_addr, 16'd0);
                checkOutput("abort mem_wdata", mem_wdata, 16'd0);
                checkOutput("abort done", {15'd0, done}, 16'd0);
                checkOutput("abort sp_we", {15'd0, sp_we}, 16'd0);
                step();
                reset = 1'b0;
                step();
                checkOutput("abort done_later", {15'd0, done}, 16'd0);
                checkOutput("abort idle", {15'd0, busy}, 16'd0);
                return;
            end
            wd = (bits[k] == 4) ? 16'h1000 : 16'hA000 + 16'(bits[k]);
            if (k == 3 && abort_after < 0) begin
                start     = 1'b1;
                push_mask = 16'hFFFF;
            end
            xfer("push_r", 1'b1, 16'h1000 - 16'(2 * (k + 1)), wd, 16'd1 << bits[k], 16'd0, 0);
            start     = 1'b0;
            push_mask = 16'h01DF;
        end
        check_finish("push_r", 16'h0FF0, 9);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        mem_ack    = 1'b0;
        push_mask  = '0;
        pop_mask   = '0;
        sp_in      = '0;
        operand_in = '0;
        mem_rdata  = '0;
        step();
        step();
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset mem_req", {15'd0, mem_req}, 16'd0);
        checkOutput("reset reg_sel", reg_sel, 16'd0);
        checkOutput("reset operand_out", operand_out, 16'd0);
        checkOutput("reset done", {15'd0, done}, 16'd0);
        reset = 1'b0;
        step();

        $display("[TB] PUSH R with stray start");
        push_r(-1);

        // POP R starts in the very cycle busy falls.
        $display("[TB] POP R");
        begin
            int bits [8] = '{8, 7, 6, 5, 3, 2, 1, 0};
            reg_we_count = 0;
            applyStimulus(16'h0000, 16'h01EF, 16'h0FF0);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) begin
                    checkOutput("pop_r reg_we", {15'd0, reg_we}, {15'd0, bits[k-1] != 5});
                    if (bits[k-1] != 5) begin
                        checkOutput("pop_r reg_wdata", reg_wdata, 16'h5000 + 16'(bits[k-1]));
                        checkOutput("pop_r wb_sel", reg_sel, 16'd1 << bits[k-1]);
                    end
                end
                xfer("pop_r", 1'b0, 16'h0FF0 + 16'(2 * k), 16'd0,
                     (k == 0) ? 16'h0100 : 16'd0, 16'h5000 + 16'(bits[k]), 0);
            end
            checkOutput("pop_r last reg_we", {15'd0, reg_we}, 16'd1);
            checkOutput("pop_r last reg_wdata", reg_wdata, 16'h5000);
            checkOutput("pop_r last wb_sel", reg_sel, 16'h0001);
            check_finish("pop_r", 16'h1000, 9);
            checkOutput("pop_r reg_we_pulses", 16'(reg_we_count), 16'd7);
        end

        $display("[TB] interrupt entry with wait states");
        applyStimulus(16'h4C00, 16'h0000, 16'h0004);
        xfer("int PSW", 1'b1, 16'h0002, 16'hA00A, 16'h0400, 16'd0, 2);
        xfer("int PS", 1'b1, 16'h0000, 16'hA00B, 16'h0800, 16'd0, 2);
        xfer("int PC", 1'b1, 16'hFFFE, 16'hA00E, 16'h4000, 16'd0, 2);
        check_finish("int", 16'hFFFE, 10);

        $display("[TB] operand round trip");
        operand_in = 16'hBEEF;
        applyStimulus(16'h8000, 16'h0000, 16'h0100);
        xfer("op push", 1'b1, 16'h00FE, 16'hBEEF, 16'h8000, 16'd0, 0);
        check_finish("op push", 16'h00FE, 2);
        applyStimulus(16'h0000, 16'h8000, 16'h00FE);
        xfer("op pop", 1'b0, 16'h00FE, 16'd0, 16'h8000, 16'h1234, 0);
        checkOutput("op pop valid", {15'd0, operand_valid}, 16'd1);
        checkOutput("op pop out", operand_out, 16'h1234);
        checkOutput("op pop no reg_we", {15'd0, reg_we}, 16'd0);
        check_finish("op pop", 16'h0100, 2);
        checkOutput("op pop valid_after", {15'd0, operand_valid}, 16'd0);
        checkOutput("op pop out_held", operand_out, 16'h1234);

        $display("[TB] pushed SP_DISCARD");
        applyStimulus(16'h0021, 16'h0000, 16'h0200);
        xfer("discard AW", 1'b1, 16'h01FE, 16'hA000, 16'h0001, 16'd0, 0);
        checkOutput("discard no req", {15'd0, mem_req}, 16'd0);
        checkOutput("discard busy", {15'd0, busy}, 16'd1);
        step();
        check_finish("discard", 16'h01FE, 3);

        $display("[TB] empty masks with stray ack");
        mem_ack = 1'b1;
        applyStimulus(16'h0000, 16'h0000, 16'h2222);
        checkOutput("empty no req", {15'd0, mem_req}, 16'd0);
        check_finish("empty", 16'h2222, 1);
        mem_ack = 1'b0;

        $display("[TB] reset mid-sequence, then rerun");
        push_r(2);
        push_r(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
